// File: rtl/axis_rr_arbiter.sv
// Round-robin, packet-locked AXI-Stream arbiter: four slave streams merged onto one registered master.
// Optional macro AXIS_ARB_PKT_CNT_EN adds per-requester 8-bit end-of-packet counters on pkt_cnt.
//
// state | meaning
// IDLE  | no grant held; arbitrate among valid requesters starting at rr_ptr
// XFER  | grant locked to one requester until its s_last beat is accepted
module axis_rr_arbiter #(
  parameter int DW   = 8,
  parameter int NREQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DW*NREQ-1:0] s_data,
  input  logic [NREQ-1:0]    s_valid,
  input  logic [NREQ-1:0]    s_last,
  output logic [NREQ-1:0]    s_ready,
  output logic [DW-1:0]      m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic [1:0]         grant,
  output logic               busy
`ifdef AXIS_ARB_PKT_CNT_EN
  ,
  output logic [DW*NREQ-1:0] pkt_cnt
`endif
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t        state_q, state_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [1:0]    grant_q, grant_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;

  logic [1:0]    pick;
  logic [1:0]    idx;
  logic          found;
  logic          out_free;
  logic          accept;

  // First valid requester at or above rr_ptr, wrapping 3->0.
  always_comb begin
    pick  = rr_ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!found && s_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign out_free = !m_valid_q || m_ready;
  assign accept   = (state_q == XFER) && s_valid[grant_q] && out_free;

  always_comb begin
    s_ready = '0;
    if (state_q == XFER) begin
      s_ready[grant_q] = out_free;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;

    if (accept) begin
      m_data_d  = s_data[grant_q*DW +: DW];
      m_last_d  = s_last[grant_q];
      m_valid_d = 1'b1;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = XFER;
        end
      end
      XFER: begin
        // Only the last beat releases the grant; gaps in s_valid keep it locked.
        if (accept && s_last[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = grant_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign grant   = grant_q;
  assign busy    = (state_q == XFER);

`ifdef AXIS_ARB_PKT_CNT_EN
  logic [7:0] cnt_q [NREQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (accept && s_last[grant_q]) begin
      cnt_q[grant_q] <= cnt_q[grant_q] + 8'd1;
    end
  end

  always_comb begin
    pkt_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      pkt_cnt[DW*i +: DW] = DW'(cnt_q[i]);
    end
  end
`endif

endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 Parameter DW, default 8: data width per stream.
REQ-002 Parameter NREQ, fixed at 4: number of requesting slave streams.
REQ-003 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-low.
REQ-005 Port s_data, input, DW*NREQ: requester i data in bits [DW*i+DW-1 : DW*i].
REQ-006 Port s_valid, input, NREQ: per-requester valid.
REQ-007 Port s_last, input, NREQ: per-requester end-of-packet.
REQ-008 Port s_ready, output, NREQ: per-requester ready; at most one bit is high at any time.
REQ-009 Port m_data, output, DW: merged stream data, registered.
REQ-010 Port m_valid, output, 1: merged stream valid, registered.
REQ-011 Port m_ready, input, 1: downstream ready.
REQ-012 Port m_last, output, 1: merged stream end-of-packet, registered.
REQ-013 Port grant, output, 2: index of the current or most recent grantee.
REQ-014 Port busy, output, 1: high while in XFER.

Function
REQ-015 The FSM shall have two states: IDLE and XFER.
REQ-016 In IDLE with any s_valid high, the arbiter shall pick the first requester with s_valid high, searching upward from rr_ptr and wrapping 3->0, load grant, and enter XFER on the next edge.
REQ-017 In IDLE, all s_ready bits shall be 0; with no s_valid, the FSM shall stay in IDLE.
REQ-018 In XFER, s_ready[grant] shall be (!m_valid || m_ready) and all other s_ready bits shall be 0 (combinational).
REQ-019 A beat is accepted when s_valid[grant] && s_ready[grant]; on that edge, m_data, m_last and m_valid load the beat (m_valid=1).
REQ-020 With no accepted beat and m_ready=1, m_valid shall clear to 0.
REQ-021 With m_valid=1 and m_ready=0, m_data, m_valid and m_last shall hold.
REQ-022 Acceptance to m_valid latency shall be 1 cycle; with s_valid and m_ready both held high, throughput shall be 1 beat/cycle.
REQ-023 Grant is packet-locked: an accepted beat with s_last=1 shall return the FSM to IDLE and set rr_ptr=grant+1 mod 4.
REQ-024 A gap in s_valid[grant] inside a packet shall not release the grant.
REQ-025 Changes in other requesters' s_valid during XFER shall be ignored.
REQ-026 Minimum grant overhead: one IDLE cycle between packets, so m_valid has at most one idle beat between back-to-back packets.
REQ-027 grant shall hold its value in IDLE until the next arbitration.

Reset
REQ-028 rst low shall immediately clear state=IDLE, rr_ptr=0, grant=0, m_valid=0, m_last=0, m_data=0 and s_ready=0.
REQ-029 A reset mid-packet shall drop the packet with no m_valid output, and arbitration shall restart from requester 0.
REQ-030 Reset release is synchronized to clk by the system reset generator; the block adds no synchronizer.

Configuration
REQ-031 Macro AXIS_ARB_PKT_CNT_EN: when defined, add output pkt_cnt, DW*NREQ wide, with per-requester 8-bit counters.
REQ-032 With AXIS_ARB_PKT_CNT_EN defined, each counter shall increment on every accepted s_last beat of its requester, wrap 255->0, and clear on reset.
REQ-033 Without AXIS_ARB_PKT_CNT_EN, the pkt_cnt port and counters shall be absent and all other behaviour shall be identical.

Verification
REQ-034 Single source: req1 sends a 3-beat packet 0x11,0x22,0x33 with m_ready=1 -> m_data is 0x11,0x22,0x33 on consecutive cycles, m_last only with 0x33, grant=1.
REQ-035 All four sources valid with 2-beat packets -> grant order is 0,1,2,3,0 and each packet is contiguous on m_data.
REQ-036 m_ready held low for 3 cycles mid-packet -> m_data and m_valid are stable, s_ready[grant]=0, and no beat is lost or duplicated.
REQ-037 req2 drops s_valid for 2 cycles mid-packet while req0 is valid -> grant stays 2 until s_last.
REQ-038 rst pulsed low during beat 2 of 4 -> outputs clear that cycle, and the next arbitration grants the lowest valid index from 0.
REQ-039 With AXIS_ARB_PKT_CNT_EN defined, send 257 packets from req3 -> pkt_cnt[31:24]=1.
